sobel_stream: RTL
=================

SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameter PIX_W, default 8, pixel bit width (4..12).
REQ-002 Parameter IMG_W, default 640, pixels per image line (4..2048).
REQ-003 Port clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port in_valid  input  1  input pixel present.
REQ-006 Port in_ready  output  1  block accepts in_pix this cycle.
REQ-007 Port in_sof  input  1  qualifies in_pix as first pixel of frame (row 0, col 0).
REQ-008 Port in_pix  input  PIX_W  raster-order input pixel, unsigned.
REQ-009 Port out_valid  output  1  out_pix valid.
REQ-010 Port out_ready  input  1  downstream accepts out_pix.
REQ-011 Port out_pix  output  PIX_W  edge magnitude, unsigned.

Function
REQ-012 A transfer occurs on a cycle with in_valid && in_ready; only transfers update counters, line buffers or window.
REQ-013 in_ready = !out_valid || out_ready; the pipeline advances only when in_ready is 1.
REQ-014 Column counter: 0..IMG_W-1, increments per transfer, wraps to 0 after IMG_W-1; row counter increments on wrap, saturating at 2.
REQ-015 Transfer with in_sof=1: pixel taken as (row 0, col 0); counters restart from there regardless of previous position.
REQ-016 Two line buffers of depth IMG_W hold the previous two rows; a 3x3 window shift register holds p0..p8 (p0 top-left, p4 centre, p8 bottom-right).
REQ-017 Window complete when the current transfer has row>=2 and col>=2; only complete windows produce output; border pixels produce none; a frame of H rows yields (H-2)*(IMG_W-2) outputs.
REQ-018 Stage 1 registers gx = (p2-p0) + 2(p5-p3) + (p8-p6) and gy = (p0-p6) + 2(p1-p7) + (p2-p8), each signed PIX_W+3 bits, no overflow.
REQ-019 Stage 2 registers |gx|+|gy| as unsigned PIX_W+3 bits, then saturates: out_pix = 2^PIX_W-1 if any bit above PIX_W-1 set, else low PIX_W bits.
REQ-020 Latency: completing transfer at cycle t gives out_valid=1 at t+2 with no stall; each stall cycle adds one.
REQ-021 While out_valid && !out_ready, out_pix, out_valid and all internal state hold stable.
REQ-022 Non-transfer cycles with in_ready=1 insert a bubble (valid 0) in the pipeline; no output duplicated or dropped.
REQ-023 in_sof with mid-line position discards the partial window; pipeline results already in flight still emit.

Reset
REQ-024 rst_n=0 at a clock edge: out_valid=0, out_pix=0, counters=0, stage valids=0; line buffer and window data need not clear.
REQ-025 in_ready=1 during and after reset; first transfer after reset is treated as (0,0) even without in_sof.
REQ-026 Reset mid-frame aborts the frame; in-flight results never emit.

Configuration
REQ-027 Macro SOBEL_STREAM_THRESH_EN defined: extra port thresh input PIX_W; out_pix = all-ones if stage-2 saturated magnitude >= thresh, else 0; same latency.
REQ-028 Macro undefined: thresh port absent; out_pix is the saturated magnitude of REQ-019.

Verification
REQ-029 PIX_W=8, IMG_W=4, 4x4 frame all 100, out_ready=1 -> exactly 4 outputs, all 0, each 2 cycles after its completing transfer.
REQ-030 IMG_W=4, columns 0,0,255,255 each row -> gx=1020, gy=0 -> out_pix 255 for every output.
REQ-031 Single pixel 10 at (1,1), rest 0 -> windows centred (1,1),(1,2),(2,1),(2,2) give out_pix 0,20,20,20... checked against reference model of REQ-018/019.
REQ-032 out_ready low for 5 cycles during stream -> in_ready low, out_pix stable, no output lost; totals match.
REQ-033 in_sof asserted at (2,3) then new frame -> no output from partial window; new frame output count (H-2)*(IMG_W-2).
REQ-034 SOBEL_STREAM_THRESH_EN, thresh=50, vertical step 0|40 -> magnitude 160 -> 255; step 0|10 -> 40 -> 0; rst_n low mid-frame -> out_valid 0 next cycle.

Source files
------------

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge-magnitude filter with ready/valid handshake and 2-stage pipeline.
// Optional threshold output mode selected by macro SOBEL_STREAM_THRESH_EN.
module sobel_stream #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 640
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SOBEL_STREAM_THRESH_EN
    input  logic [PIX_W-1:0] thresh,
`endif
    output logic [PIX_W-1:0] out_pix
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned GW = PIX_W + 3;

    logic [CW-1:0]           r_col, w_col, w_col_nxt;
    logic [1:0]              r_row, w_row, w_row_nxt;
    logic                    w_xfer, w_done;
    logic [PIX_W-1:0]        r_win [9];
    logic [PIX_W-1:0]        w_win [9];
    logic [PIX_W-1:0]        r_lb0 [IMG_W];
    logic [PIX_W-1:0]        r_lb1 [IMG_W];
    logic signed [GW-1:0]    w_gx, w_gy, r_gx, r_gy;
    logic                    r_s1_v;
    logic [GW-1:0]           w_ax, w_ay, w_mag;
    logic [PIX_W-1:0]        w_sat, w_out;

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    assign in_ready = !rst_n || !out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;

    // in_sof overrides the tracked position so a new frame always starts at (0,0).
    always_comb begin
        w_col     = in_sof ? '0 : r_col;
        w_row     = in_sof ? 2'd0 : r_row;
        w_col_nxt = w_col + 1'b1;
        w_row_nxt = w_row;
        if (w_col == CW'(IMG_W - 1)) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
        end
        w_done = (w_row == 2'd2) && (w_col >= CW'(2));
    end

    // Window as it will be after this transfer shifts in the new column.
    always_comb begin
        w_win[0] = r_win[1];
        w_win[1] = r_win[2];
        w_win[2] = r_lb0[w_col];
        w_win[3] = r_win[4];
        w_win[4] = r_win[5];
        w_win[5] = r_lb1[w_col];
        w_win[6] = r_win[7];
        w_win[7] = r_win[8];
        w_win[8] = in_pix;
    end

    always_comb begin
        w_gx = (ext(w_win[2]) - ext(w_win[0])) + ((ext(w_win[5]) - ext(w_win[3])) <<< 1)
             + (ext(w_win[8]) - ext(w_win[6]));
        w_gy = (ext(w_win[0]) - ext(w_win[6])) + ((ext(w_win[1]) - ext(w_win[7])) <<< 1)
             + (ext(w_win[2]) - ext(w_win[8]));
    end

    always_comb begin
        w_ax  = r_gx[GW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
        w_ay  = r_gy[GW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
        w_mag = w_ax + w_ay;
        w_sat = (|w_mag[GW-1:PIX_W]) ? '1 : w_mag[PIX_W-1:0];
`ifdef SOBEL_STREAM_THRESH_EN
        w_out = (w_sat >= thresh) ? '1 : '0;
`else
        w_out = w_sat;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= 2'd0;
            r_s1_v    <= 1'b0;
            out_valid <= 1'b0;
            out_pix   <= '0;
        end else if (in_ready) begin
            r_s1_v    <= w_xfer && w_done;
            out_valid <= r_s1_v;
            if (r_s1_v) begin
                out_pix <= w_out;
            end
            if (w_xfer) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
            end
        end
    end

    // Pixel storage needs no reset; validity is tracked by the counters and stage valids.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= w_win[i];
            end
            r_lb0[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= in_pix;
            r_gx         <= w_gx;
            r_gy         <= w_gy;
        end
    end

endmodule
